// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - shared encodings and defaults for the multiply/divide unit
package mult_div_pkg;

    localparam int LARGURA_PADRAO = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_NOP0  = 3'b110,
        OP_NOP1  = 3'b111
    } operacao_t;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        AJUSTA  = 2'd2
    } estado_t;

endpackage

// File: rtl/passo_mult_div.sv
// rtl/passo_mult_div.sv - one iteration of shift-add multiply / restoring divide
module passo_mult_div
    import mult_div_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) (
    input  logic               modo_div,
    input  logic [LARGURA-1:0] acc,
    input  logic [LARGURA-1:0] q,
    input  logic [LARGURA-1:0] operando,
    output logic [LARGURA-1:0] acc_prox,
    output logic [LARGURA-1:0] q_prox
);

    logic [LARGURA:0]   soma;
    logic [LARGURA:0]   deslocado;
    logic [LARGURA-1:0] dif;
    logic               cabe;

    // Multiply: {acc,q} is the partial product, q[0] selects add-or-pass, then shift right.
    // Divide: shift remainder left taking the next dividend bit from q, trial-subtract.
    always_comb begin
        soma      = {1'b0, acc} + (q[0] ? {1'b0, operando} : '0);
        deslocado = {acc, q[LARGURA-1]};
        dif       = deslocado[LARGURA-1:0] - operando;
        cabe      = (deslocado >= {1'b0, operando});
        if (modo_div) begin
            acc_prox = cabe ? dif : deslocado[LARGURA-1:0];
            q_prox   = {q[LARGURA-2:0], cabe};
        end else begin
            acc_prox = soma[LARGURA:1];
            q_prox   = {soma[0], q[LARGURA-1:1]};
        end
    end

endmodule

// File: rtl/unidade_mult_div.sv
// rtl/unidade_mult_div.sv - iterative MIPS HI/LO multiply/divide unit (divider gated by MULT_DIV_DIVISAO_EN)
module unidade_mult_div
    import mult_div_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               Inicio,
    input  logic [2:0]         Operacao,
    input  logic [LARGURA-1:0] Rs,
    input  logic [LARGURA-1:0] Rt,
    output logic               Ocupado,
    output logic               Pronto,
    output logic               Div_zero,
    output logic [LARGURA-1:0] Hi,
    output logic [LARGURA-1:0] Lo
);

    localparam int CW = $clog2(LARGURA);

    estado_t              estado;
    logic [CW-1:0]        cnt;
    logic [LARGURA-1:0]   acc;
    logic [LARGURA-1:0]   q;
    logic [LARGURA-1:0]   b;
    logic                 eh_div;
    logic                 neg_q;
    logic                 neg_r;
    logic                 zero_flag;

    logic [LARGURA-1:0]   acc_prox;
    logic [LARGURA-1:0]   q_prox;

    logic                 com_sinal;
    logic                 neg_rs;
    logic                 neg_rt;
    logic [LARGURA-1:0]   mag_rs;
    logic [LARGURA-1:0]   mag_rt;
    logic                 rt_zero;
    logic [2*LARGURA-1:0] produto;
    logic [2*LARGURA-1:0] produto_neg;

    // Operand magnitudes and signs for the signed ops, taken straight from the register file
    always_comb begin
        com_sinal   = (Operacao == OP_MULT) || (Operacao == OP_DIV);
        neg_rs      = com_sinal & Rs[LARGURA-1];
        neg_rt      = com_sinal & Rt[LARGURA-1];
        mag_rs      = neg_rs ? -Rs : Rs;
        mag_rt      = neg_rt ? -Rt : Rt;
        rt_zero     = (Rt == '0);
        produto     = {acc, q};
        produto_neg = -produto;
    end

    passo_mult_div #(.LARGURA(LARGURA)) u_passo (
        .modo_div (eh_div),
        .acc      (acc),
        .q        (q),
        .operando (b),
        .acc_prox (acc_prox),
        .q_prox   (q_prox)
    );

    // Control FSM, iteration counter, sign correction and the architectural HI/LO registers
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            estado    <= OCIOSO;
            cnt       <= '0;
            acc       <= '0;
            q         <= '0;
            b         <= '0;
            eh_div    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            zero_flag <= 1'b0;
            Hi        <= '0;
            Lo        <= '0;
            Ocupado   <= 1'b0;
            Pronto    <= 1'b0;
            Div_zero  <= 1'b0;
        end else begin
            Pronto   <= 1'b0;
            Div_zero <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (Inicio) begin
                        case (operacao_t'(Operacao))
                            OP_MULT, OP_MULTU: begin
                                acc       <= '0;
                                q         <= mag_rt;
                                b         <= mag_rs;
                                eh_div    <= 1'b0;
                                neg_q     <= neg_rs ^ neg_rt;
                                neg_r     <= 1'b0;
                                zero_flag <= 1'b0;
                                cnt       <= '0;
                                Ocupado   <= 1'b1;
                                estado    <= CALCULA;
                            end
                            OP_DIV, OP_DIVU: begin
`ifdef MULT_DIV_DIVISAO_EN
                                acc    <= '0;
                                eh_div <= 1'b1;
                                cnt    <= '0;
                                if (rt_zero) begin
                                    // Zero divisor: raw dividend so the remainder comes back as Rs
                                    q         <= Rs;
                                    b         <= '0;
                                    neg_q     <= 1'b0;
                                    neg_r     <= 1'b0;
                                    zero_flag <= 1'b1;
                                end else begin
                                    q         <= mag_rs;
                                    b         <= mag_rt;
                                    neg_q     <= neg_rs ^ neg_rt;
                                    neg_r     <= neg_rs;
                                    zero_flag <= 1'b0;
                                end
                                Ocupado <= 1'b1;
                                estado  <= CALCULA;
`else
                                // No divider: acknowledge immediately and leave HI/LO alone
                                Pronto <= 1'b1;
`endif
                            end
                            OP_MTHI: Hi <= Rs;
                            OP_MTLO: Lo <= Rs;
                            default: ;
                        endcase
                    end
                end
                CALCULA: begin
                    acc <= acc_prox;
                    q   <= q_prox;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(LARGURA - 1)) begin
                        estado <= AJUSTA;
                    end
                end
                AJUSTA: begin
                    if (eh_div) begin
                        Lo <= neg_q ? -q : q;
                        Hi <= neg_r ? -acc : acc;
                    end else begin
                        {Hi, Lo} <= neg_q ? produto_neg : produto;
                    end
                    Div_zero <= zero_flag;
                    Pronto   <= 1'b1;
                    Ocupado  <= 1'b0;
                    estado   <= OCIOSO;
                end
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_unidade_mult_div.sv
// tb/tb_unidade_mult_div.sv - self-checking bench for unidade_mult_div
module tb_unidade_mult_div;
    import mult_div_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        Inicio;
    logic [2:0]  Operacao;
    logic [31:0] Rs;
    logic [31:0] Rt;
    logic        Ocupado;
    logic        Pronto;
    logic        Div_zero;
    logic [31:0] Hi;
    logic [31:0] Lo;

    always #5 Clock = ~Clock;

    unidade_mult_div #(.LARGURA(32)) dut (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .Inicio   (Inicio),
        .Operacao (Operacao),
        .Rs       (Rs),
        .Rt       (Rt),
        .Ocupado  (Ocupado),
        .Pronto   (Pronto),
        .Div_zero (Div_zero),
        .Hi       (Hi),
        .Lo       (Lo)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } esp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    esp_t        sb[$];
    vec_t        tabela[12];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] hi_m     = 32'h0;
    logic [31:0] lo_m     = 32'h0;

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nome, got, exp);
        end
    endtask

    // Scoreboard: every Pronto pulse retires the oldest expected result
    always @(negedge Clock) begin
        if (Reset_n === 1'b1 && Pronto === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pronto_unexpected got=1 exp=0");
            end else begin
                esp_t e;
                e = sb.pop_front();
                check("sb_hi", Hi, e.hi);
                check("sb_lo", Lo, e.lo);
                check("sb_div_zero", {31'b0, Div_zero}, {31'b0, e.dz});
            end
        end
    end

    task automatic run_op(input string nome, input logic [2:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [31:0] eh, input logic [31:0] el,
                          input logic edz, input bit mid_mtlo);
        int   lat      = 0;
        int   ocup     = 0;
        int   exp_lat  = 34;
        int   exp_ocup = 33;
        esp_t e;
`ifndef MULT_DIV_DIVISAO_EN
        if (op == OP_DIV || op == OP_DIVU) begin
            eh       = hi_m;
            el       = lo_m;
            edz      = 1'b0;
            exp_lat  = 1;
            exp_ocup = 0;
        end
`endif
        e.hi = eh;
        e.lo = el;
        e.dz = edz;
        sb.push_back(e);
        Operacao = op;
        Rs       = rs;
        Rt       = rt;
        Inicio   = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge Clock);
            if (k == 1) begin
                Inicio = 1'b0;
                Rs     = $urandom;
                Rt     = $urandom;
            end
            if (mid_mtlo && k == 5) begin
                Inicio   = 1'b1;
                Operacao = OP_MTLO;
                Rs       = 32'h0000DEAD;
            end
            if (mid_mtlo && k == 6) Inicio = 1'b0;
            if (mid_mtlo && k == 8) check({nome, "_lo_hold"}, Lo, lo_m);
            if (Ocupado === 1'b1) ocup++;
            if (Pronto === 1'b1) begin
                lat = k;
                break;
            end
        end
        check({nome, "_latency"}, 32'(lat), 32'(exp_lat));
        check({nome, "_busy_cycles"}, 32'(ocup), 32'(exp_ocup));
        hi_m = eh;
        lo_m = el;
    endtask

    initial begin
        int pronto_vistos;
        logic [2:0] op_abort;

        tabela[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        tabela[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tabela[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tabela[3]  = '{OP_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
        tabela[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        tabela[5]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        tabela[6]  = '{OP_MULTU, 32'h12345678, 32'h00000009, 32'h00000000, 32'hA3D70A38, 1'b0};
        tabela[7]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFD, 32'h00000001, 32'hFFFFFFFE, 1'b0};
        tabela[8]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        tabela[9]  = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        tabela[10] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
        tabela[11] = '{OP_MULTU, 32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000, 1'b0};

        Reset_n  = 1'b0;
        Inicio   = 1'b0;
        Operacao = 3'b000;
        Rs       = 32'h0;
        Rt       = 32'h0;
        repeat (3) @(negedge Clock);
        check("reset_hi", Hi, 32'h0);
        check("reset_lo", Lo, 32'h0);
        check("reset_ocupado", {31'b0, Ocupado}, 32'h0);
        check("reset_pronto", {31'b0, Pronto}, 32'h0);
        check("reset_div_zero", {31'b0, Div_zero}, 32'h0);
        Reset_n = 1'b1;
        @(negedge Clock);

        // MTHI / MTLO while idle, then a no-op code
        Operacao = OP_MTHI; Rs = 32'h12345678; Inicio = 1'b1;
        @(negedge Clock);
        Inicio = 1'b0;
        check("mthi_hi", Hi, 32'h12345678);
        check("mthi_ocupado", {31'b0, Ocupado}, 32'h0);
        check("mthi_pronto", {31'b0, Pronto}, 32'h0);
        Operacao = OP_MTLO; Rs = 32'hCAFEBABE; Inicio = 1'b1;
        @(negedge Clock);
        Inicio = 1'b0;
        check("mtlo_lo", Lo, 32'hCAFEBABE);
        check("mtlo_hi_kept", Hi, 32'h12345678);
        hi_m = 32'h12345678;
        lo_m = 32'hCAFEBABE;
        Operacao = OP_NOP0; Rs = 32'h0000FFFF; Inicio = 1'b1;
        @(negedge Clock);
        Inicio = 1'b0;
        check("nop_hi", Hi, hi_m);
        check("nop_lo", Lo, lo_m);
        check("nop_ocupado", {31'b0, Ocupado}, 32'h0);

        // Table of operations, issued back to back
        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), tabela[i].op, tabela[i].rs, tabela[i].rt,
                   tabela[i].hi, tabela[i].lo, tabela[i].dz, 1'b0);
        end

        // MTLO issued mid-multiply is ignored
        run_op("mtlo_mid_mult", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b1);

        // Second op accepted in the Pronto cycle of the first
        run_op("b2b_first", OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b0);
        run_op("b2b_second", OP_DIVU, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0, 1'b0);

        // Reset during iteration 10 discards the operation
`ifdef MULT_DIV_DIVISAO_EN
        op_abort = OP_DIVU;
`else
        op_abort = OP_MULTU;
`endif
        Operacao = op_abort; Rs = 32'd100; Rt = 32'd7; Inicio = 1'b1;
        @(negedge Clock);
        Inicio = 1'b0;
        repeat (9) @(negedge Clock);
        Reset_n = 1'b0;
        #1;
        check("abort_ocupado", {31'b0, Ocupado}, 32'h0);
        check("abort_hi", Hi, 32'h0);
        check("abort_lo", Lo, 32'h0);
        @(negedge Clock);
        Reset_n = 1'b1;
        hi_m = 32'h0;
        lo_m = 32'h0;
        pronto_vistos = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clock);
            if (Pronto === 1'b1) pronto_vistos++;
        end
        check("abort_no_pronto", 32'(pronto_vistos), 32'h0);
        run_op("after_reset", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0);

        repeat (2) @(negedge Clock);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
